n64_poll_scheduler: RTL and testbench

Periodic poll sequencer sitting between system logic and the N64 controller serial interface. It issues single-cycle poll starts at a fixed rate and detects transaction completion from the interface's `alive` toggle. It flags a missing controller by timeout and captures the 34-bit button word into a decoded snapshot with press/release edge events. The snapshot goes to a consumer through a valid/ready handshake.

---
 rtl/n64_pkg.sv | 44 ++++
 rtl/n64_alive_sync.sv | 38 +++
 rtl/n64_poll_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_n64_poll_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : n64_pkg
//  Description : Shared constants and FSM encoding for the N64 poll scheduler:
//                button-word field positions, pad button indices, states.
//  Revision    : 1.0 - initial release
// ============================================================================
package n64_pkg;

    // Field positions inside the 34-bit controller word
    localparam int PAD_LSB = 1;
    localparam int PAD_MSB = 16;
    localparam int X_LSB   = 17;
    localparam int Y_LSB   = 25;

    // Bit indices inside the 16-bit decoded pad word
    localparam int BTN_A       = 0;
    localparam int BTN_B       = 1;
    localparam int BTN_Z       = 2;
    localparam int BTN_START   = 3;
    localparam int BTN_D_UP    = 4;
    localparam int BTN_D_DOWN  = 5;
    localparam int BTN_D_LEFT  = 6;
    localparam int BTN_D_RIGHT = 7;
    localparam int BTN_RSV0    = 8;
    localparam int BTN_RSV1    = 9;
    localparam int BTN_L       = 10;
    localparam int BTN_R       = 11;
    localparam int BTN_C_UP    = 12;
    localparam int BTN_C_DOWN  = 13;
    localparam int BTN_C_LEFT  = 14;
    localparam int BTN_C_RIGHT = 15;

    // Scheduler FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/n64_alive_sync.sv
`default_nettype none
// ============================================================================
//  Module      : n64_alive_sync
//  Description : Two-flop synchronizer for the interface alive toggle plus a
//                toggle detector giving a registered one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module n64_alive_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic alive_i,
    output logic done_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic done_q;

    // Synchronize alive, remember its last value and flag any change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            meta_q <= alive_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            done_q <= sync_q ^ prev_q;
        end
    end

    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/n64_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : n64_poll_scheduler
//  Description : Periodic poll sequencer for the N64 controller interface.
//                Issues poll starts, detects completion/timeout, captures a
//                decoded button snapshot with press/release edge events and
//                hands it to a consumer over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module n64_poll_scheduler
    import n64_pkg::*;
#(
    parameter int POLL_PERIOD = 1_000_000,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic        clk_50MHZ,
    input  logic        rst_n,
    input  logic        enable,
    output logic        poll_start,
    input  logic        ctrl_alive,
    input  logic [33:0] ctrl_buttons,
    output logic        state_valid,
    input  logic        state_ready,
    output logic [15:0] pad_buttons,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic [15:0] pressed,
    output logic [15:0] released,
    output logic        connected,
    output logic [7:0]  miss_count
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_SAT  = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [PW-1:0] period_q;
    logic [TW-1:0] timeout_q;
    logic          w_done;
    logic          w_capture;
    logic          w_timeout;
    logic          w_accept;

    logic          poll_start_q;
    logic          valid_q;
    logic          connected_q;
    logic [7:0]    miss_q;
    logic [15:0]   pad_q;
    logic [15:0]   prev_q;
    logic [7:0]    x_q;
    logic [7:0]    y_q;
    logic [15:0]   pressed_q;
    logic [15:0]   released_q;

    logic [15:0]   w_pad;
    logic [15:0]   w_new_pressed;
    logic [15:0]   w_new_released;
    logic          unused_bits;

    n64_alive_sync u_alive_sync (
        .clk     (clk_50MHZ),
        .rst_n   (rst_n),
        .alive_i (ctrl_alive),
        .done_o  (w_done)
    );

    assign w_pad          = ctrl_buttons[PAD_MSB:PAD_LSB];
    assign w_new_pressed  = w_pad & ~prev_q;
    assign w_new_released = ~w_pad & prev_q;
    assign w_accept       = valid_q & state_ready;
    assign unused_bits    = ctrl_buttons[0] ^ ctrl_buttons[33];

    // FSM state register
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done is only honoured in WAIT, timeout fires once
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done) begin
                    state_d = ST_CAPTURE;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (period_q == PERIOD_LAST) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Period and timeout counters; the ISSUE cycle counts as period cycle 0
    // so starts land exactly POLL_PERIOD apart. Both saturate.
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            timeout_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            period_q  <= PW'(1);
            timeout_q <= '0;
        end else begin
            if (period_q != PERIOD_LAST) period_q <= period_q + PW'(1);
            if (timeout_q != TIMEOUT_SAT) timeout_q <= timeout_q + TW'(1);
        end
    end

    // Registered outputs: start pulse, link status, snapshot and edge events
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            poll_start_q <= 1'b0;
            valid_q      <= 1'b0;
            connected_q  <= 1'b0;
            miss_q       <= 8'd0;
            pad_q        <= 16'd0;
            prev_q       <= 16'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            pressed_q    <= 16'd0;
            released_q   <= 16'd0;
        end else begin
            poll_start_q <= (state_d == ST_ISSUE);
            if (w_timeout) begin
                connected_q <= 1'b0;
                if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
            end
            if (w_capture) begin
                pad_q       <= w_pad;
                prev_q      <= w_pad;
                x_q         <= ctrl_buttons[X_LSB+7:X_LSB];
                y_q         <= ctrl_buttons[Y_LSB+7:Y_LSB];
                connected_q <= 1'b1;
                valid_q     <= 1'b1;
                // An accept in the same cycle consumes the old events
                if (w_accept) begin
                    pressed_q  <= w_new_pressed;
                    released_q <= w_new_released;
                end else begin
                    pressed_q  <= pressed_q | w_new_pressed;
                    released_q <= released_q | w_new_released;
                end
            end else if (w_accept) begin
                valid_q    <= 1'b0;
                pressed_q  <= 16'd0;
                released_q <= 16'd0;
            end
        end
    end

    assign poll_start  = poll_start_q;
    assign state_valid = valid_q;
    assign connected   = connected_q;
    assign miss_count  = miss_q;
    assign pad_buttons = pad_q;
    assign stick_x     = x_q;
    assign stick_y     = y_q;
    assign pressed     = pressed_q;
    assign released    = released_q;

endmodule
`default_nettype wire

// File: tb/tb_n64_poll_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_n64_poll_scheduler
//  Description : Self-checking bench for n64_poll_scheduler with a behavioural
//                controller interface model and a snapshot scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_poll_scheduler;

    localparam int P  = 100;
    localparam int TO = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        ctrl_alive = 1'b0;
    logic        state_ready = 1'b0;
    logic [33:0] ctrl_buttons = '0;
    logic        poll_start;
    logic        state_valid;
    logic        connected;
    logic [15:0] pad_buttons;
    logic [15:0] pressed;
    logic [15:0] released;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic [7:0]  miss_count;

    n64_poll_scheduler #(.POLL_PERIOD(P), .TIMEOUT(TO)) dut (
        .clk_50MHZ    (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .poll_start   (poll_start),
        .ctrl_alive   (ctrl_alive),
        .ctrl_buttons (ctrl_buttons),
        .state_valid  (state_valid),
        .state_ready  (state_ready),
        .pad_buttons  (pad_buttons),
        .stick_x      (stick_x),
        .stick_y      (stick_y),
        .pressed      (pressed),
        .released     (released),
        .connected    (connected),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] pad;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] pr;
        logic [15:0] rl;
    } exp_t;

    exp_t        exp_q[$];
    logic [33:0] wq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [33:0] mkword(input logic [15:0] pad, input logic [7:0] x, input logic [7:0] y);
        return {1'b0, y, x, pad, 1'b0};
    endfunction

    task automatic push_exp(input logic [15:0] pad, input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] pr, input logic [15:0] rl);
        exp_t e;
        e.pad = pad; e.x = x; e.y = y; e.pr = pr; e.rl = rl;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural controller interface: alive toggles 40 cycles after a start
    int          tog_count = 0;
    int          tog_edge  = -1000;
    bit          model_en  = 1'b1;
    logic [33:0] model_w;
    initial begin
        forever begin
            @(negedge clk);
            if (poll_start && model_en && wq.size() > 0) begin
                model_w = wq.pop_front();
                repeat (39) @(negedge clk);
                ctrl_buttons = model_w;
                ctrl_alive   = ~ctrl_alive;
                tog_edge     = cyc + 1;
                tog_count++;
            end
        end
    end

    // Monitor: start spacing/width, valid latency, scoreboard on accept
    int   start_count = 0;
    int   last_start  = -1000;
    int   valid_rises = 0;
    bit   period_chk  = 1'b0;
    bit   have_last   = 1'b0;
    logic prev_valid  = 1'b0;
    logic prev_poll   = 1'b0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_poll) check("poll_start width", 80'(poll_start), 80'(0));
            if (poll_start) begin
                if (period_chk && have_last) check("poll period", 80'(cyc - last_start), 80'(P));
                have_last  = 1'b1;
                last_start = cyc;
                start_count++;
            end
            if (state_valid && !prev_valid) begin
                valid_rises++;
                check("valid latency", 80'(cyc - tog_edge), 80'(4));
            end
            if (state_valid && state_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected snapshot: got pad %h pressed %h, expected none", pad_buttons, pressed);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("snapshot pad/x/y/pressed/released",
                          80'({pad_buttons, stick_x, stick_y, pressed, released}), 80'(mon_e));
                end
            end
            prev_valid = state_valid;
            prev_poll  = poll_start;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_toggles(input int target, input int budget);
        int k = 0;
        while (tog_count < target && k < budget) begin
            tick();
            k++;
        end
        check("interface completions reached", 80'(tog_count >= target), 80'(1));
    endtask

    task automatic wait_cyc(input int t);
        int k = 0;
        while (cyc < t && k < 1000) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int base;
        int vr0;
        int sc;
        int s;
        tick(3);
        check("reset outputs",
              80'({poll_start, state_valid, connected, pad_buttons, stick_x, stick_y, pressed, released, miss_count}),
              80'(0));
        rst_n = 1'b1;
        tick(2);

        // Normal polling and edge events with the consumer always ready
        state_ready = 1'b1;
        wq.push_back(mkword(16'h0001, 8'h7F, 8'h00));
        wq.push_back(mkword(16'h0003, 8'h00, 8'h00));
        wq.push_back(mkword(16'h0002, 8'h00, 8'h00));
        push_exp(16'h0001, 8'h7F, 8'h00, 16'h0001, 16'h0000);
        push_exp(16'h0003, 8'h00, 8'h00, 16'h0002, 16'h0000);
        push_exp(16'h0002, 8'h00, 8'h00, 16'h0000, 16'h0001);
        period_chk = 1'b1;
        have_last  = 1'b0;
        enable     = 1'b1;
        wait_toggles(3, 400);
        tick(6);
        enable     = 1'b0;
        period_chk = 1'b0;
        check("connected/miss after polls", 80'({connected, miss_count}), 80'({1'b1, 8'd0}));

        // Backpressure: A, B, none accumulate into one snapshot
        state_ready = 1'b0;
        base = tog_count;
        vr0  = valid_rises;
        wq.push_back(mkword(16'h0001, 8'h00, 8'h00));
        wq.push_back(mkword(16'h0002, 8'h00, 8'h00));
        wq.push_back(mkword(16'h0000, 8'h00, 8'h00));
        push_exp(16'h0000, 8'h00, 8'h00, 16'h0003, 16'h0003);
        enable = 1'b1;
        wait_toggles(base + 3, 400);
        tick(6);
        enable = 1'b0;
        check("single valid under backpressure", 80'(valid_rises - vr0), 80'(1));
        state_ready = 1'b1;
        tick();
        state_ready = 1'b0;
        check("accept clears valid/pressed/released", 80'({state_valid, pressed, released}), 80'(0));

        // Capture on the same cycle as accept
        base = tog_count;
        wq.push_back(mkword(16'h0001, 8'h00, 8'h00));
        wq.push_back(mkword(16'h0002, 8'h00, 8'h00));
        push_exp(16'h0001, 8'h00, 8'h00, 16'h0001, 16'h0000);
        push_exp(16'h0002, 8'h00, 8'h00, 16'h0002, 16'h0001);
        enable = 1'b1;
        wait_toggles(base + 2, 400);
        wait_cyc(tog_edge + 3);
        state_ready = 1'b1;
        tick();
        state_ready = 1'b0;
        check("valid held on capture+accept", 80'(state_valid), 80'(1));
        enable = 1'b0;
        tick(2);
        state_ready = 1'b1;
        tick(2);

        // Timeout with a silent controller, then a late completion
        model_en = 1'b0;
        sc = start_count;
        enable = 1'b1;
        begin
            int k = 0;
            while (start_count == sc && k < 50) begin
                tick();
                k++;
            end
        end
        check("start issued for timeout test", 80'(start_count), 80'(sc + 1));
        s = last_start;
        wait_cyc(s + 60);
        check("still connected before timeout", 80'({connected, miss_count}), 80'({1'b1, 8'd0}));
        wait_cyc(s + 61);
        check("timeout drops connected", 80'({connected, miss_count}), 80'({1'b0, 8'd1}));
        wait_cyc(s + 199);
        check("no start while waiting, single miss", 80'({start_count - sc, 24'(miss_count)}), 80'({32'd1, 24'd1}));
        ctrl_buttons = mkword(16'h8000, 8'h00, 8'h80);
        ctrl_alive   = ~ctrl_alive;
        tog_edge     = s + 200;
        push_exp(16'h8000, 8'h00, 8'h80, 16'h8000, 16'h0002);
        wait_cyc(s + 204);
        check("late completion reconnects", 80'(connected), 80'(1));
        wait_cyc(s + 205);
        check("start follows late capture", 80'(poll_start), 80'(1));

        // Reset mid-WAIT with alive high, then idle toggle vs. waited toggle
        wait_cyc(s + 230);
        check("alive high at reset", 80'(ctrl_alive), 80'(1));
        enable = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        check("outputs cleared by reset",
              80'({poll_start, state_valid, connected, pad_buttons, stick_x, stick_y, pressed, released, miss_count}),
              80'(0));
        rst_n = 1'b1;
        tick(5);
        ctrl_alive = ~ctrl_alive;
        tick(10);
        check("no capture for toggle in IDLE", 80'({state_valid, connected}), 80'(0));
        base = tog_count;
        model_en = 1'b1;
        wq.push_back(mkword(16'h0001, 8'h00, 8'h00));
        push_exp(16'h0001, 8'h00, 8'h00, 16'h0001, 16'h0000);
        enable = 1'b1;
        wait_toggles(base + 1, 200);
        tick(6);
        enable = 1'b0;
        check("capture after reset reconnects", 80'(connected), 80'(1));
        tick(3);
        check("scoreboard drained", 80'(exp_q.size()), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
